alu_rol_iter: RTL and testbench
===============================

// Module: alu_rol_iter
// PURPOSE
//  Multi-cycle rotate-left unit for the ALU. It is the left-direction counterpart of the
//  combinational rotate-right path, so ROL(x,n) == ROR(x,(16-n) mod 16).
//  It rotates one bit per clock under a start/busy/done handshake.
//  It sits beside the combinational ALU ops. The execute stage stalls on busy.
// PARAMETERS
//  WIDTH      16   data width of operand1/dout
//  OFS_W      4    width of immediate_offset; must satisfy 2**OFS_W == WIDTH
// PORTS
//  clk               in   1        single clock; all state updates on its rising edge
//  reset             in   1        synchronous, active-high reset
//  start             in   1        request; sampled only in IDLE
//  operand1          in   WIDTH    value to rotate; captured with start
//  immediate_offset  in   OFS_W    left-rotate amount 0..WIDTH-1; captured with start
//  busy              out  1        high in ROTATE and DONE states
//  done              out  1        one-cycle pulse; dout valid in this cycle
//  dout              out  WIDTH    result; held until the next accepted start
//  carry             out  1        last bit rotated out; equals dout[0] when offset!=0, else 0
// BEHAVIOUR
//  - Reset (synchronous, any state, mid-operation included):
//    state=IDLE, data_q=0, cnt_q=0, busy=0, done=0, dout=0, carry=0.
//    An in-flight operation is discarded and produces no done pulse.
//  - States:
//    IDLE:   if start -> data_q<=operand1, cnt_q<=offset, carry<=0;
//            go to DONE if offset==0, else to ROTATE. If start=0, stay in IDLE.
//    ROTATE: data_q<={data_q[WIDTH-2:0],data_q[WIDTH-1]}, carry<=data_q[WIDTH-1],
//            cnt_q<=cnt_q-1; go to DONE when cnt_q==1, else stay in ROTATE.
//    DONE:   done=1 for exactly one cycle; unconditionally go to IDLE.
//  - Outputs are Moore: done=(state==DONE), busy=(state!=IDLE), dout=data_q.
//  - Latency, counted as rising edges from the start-sampling edge to done high:
//    offset N>=1 takes N+1; offset 0 takes 1.
//    start is not accepted in the DONE cycle. The next start is sampled in IDLE,
//    so throughput is one op per N+2 cycles.
//  - start while busy: ignored, with no effect on data_q, cnt_q or state.
//  - start held high across done: a new op is accepted in the first IDLE cycle.
//  - Boundary cases:
//    offset=15 does 15 single-bit rotates (no modular shortcut).
//    Values with all bits equal (0x0000, 0xFFFF) are unchanged for any offset.
//  - Width rules: cnt_q is OFS_W bits and never wraps, because decrement happens only
//    when cnt_q>=1. No arithmetic flags other than carry are produced.
//  - operand1 and immediate_offset may change after the start edge without affecting
//    the result.
// STRUCTURE
//  - Shared package/include alu_pkg:
//    state encodings ST_IDLE=2'd0, ST_ROTATE=2'd1, ST_DONE=2'd2.
//    ALU_WIDTH=16 and ALU_OFS_W=4, shared with the rotate-right ALU op.
//  - State encoding 2'd3 is illegal and recovers to ST_IDLE on the next edge.
//  - No sub-module: the one-bit rotate is an inline concatenation.
//    The FSM, counter and data register live in this file.
// TESTING
//  1. reset 3 cycles, then idle -> busy=0, done=0, dout=0x0000, carry=0 every cycle.
//  2. start, operand1=0x8001, offset=1 -> done on edge 2, dout=0x0003, carry=1, busy high 2 cycles.
//  3. start, 0x1234, offset=4 -> done on edge 5, dout=0x2341, carry=1.
//     Repeat with offset 0 -> done on edge 1, dout=0x1234, carry=0.
//  4. start, 0x0001, offset=15 -> done on edge 16, dout=0x8000.
//     Also pulse start=1 with 0xFFFF mid-operation -> it is ignored and the result is unchanged.
//  5. start, 0xA5C3, offset=7 -> assert reset on edge 3.
//     Required: no done pulse, dout=0x0000 next cycle, and a fresh op then completes normally.
//  6. Random sweep of 1000 (operand1, offset) pairs.
//     Required: dout == ROR(operand1,(16-offset)%16), done exactly once per op,
//     latency == max(offset+1,1), and start held high back-to-back yields one op per N+2 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths and rotate FSM state encodings
package alu_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int ALU_OFS_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_DONE   = 2'd2
    } rol_state_e;

endpackage

// File: rtl/alu_rol_iter.sv
// rtl/alu_rol_iter.sv - multi-cycle rotate-left unit, one bit per clock
module alu_rol_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OFS_W = ALU_OFS_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand1,
    input  logic [OFS_W-1:0] immediate_offset,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             carry
);

    rol_state_e       state_q;
    rol_state_e       state_d;
    logic [WIDTH-1:0] data_q;
    logic [OFS_W-1:0] cnt_q;
    logic             carry_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The unused encoding 2'd3 falls into the default arm and returns to idle.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (immediate_offset == '0) ? ST_DONE : ST_ROTATE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROTATE: begin
                state_d = (cnt_q == OFS_W'(1)) ? ST_DONE : ST_ROTATE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter only decrements in ROTATE, where it is always >= 1, so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        data_q  <= operand1;
                        cnt_q   <= immediate_offset;
                        carry_q <= 1'b0;
                    end
                end
                ST_ROTATE: begin
                    data_q  <= {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    carry_q <= data_q[WIDTH-1];
                    cnt_q   <= cnt_q - OFS_W'(1);
                end
                default: begin
                    data_q  <= data_q;
                    cnt_q   <= cnt_q;
                    carry_q <= carry_q;
                end
            endcase
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign dout  = data_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_alu_rol_iter.sv
// tb/tb_alu_rol_iter.sv - directed and swept checks for alu_rol_iter
module tb_alu_rol_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] operand1 = '0;
    logic [3:0]  immediate_offset = '0;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic        carry;

    int total = 0;
    int bad = 0;

    alu_rol_iter dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .operand1         (operand1),
        .immediate_offset (immediate_offset),
        .busy             (busy),
        .done             (done),
        .dout             (dout),
        .carry            (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ror(input logic [15:0] x, input int k);
        logic [15:0] v;
        v = x;
        for (int i = 0; i < k; i++) v = {v[0], v[15:1]};
        return v;
    endfunction

    // One operation: start sampled on edge 1, count edges until done, then check result.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [3:0] n,
                         input logic [15:0] exp, input bit mid);
        int lat;
        int nbusy;
        int exp_lat;
        logic exp_c;
        exp_lat = (n == 0) ? 1 : int'(n) + 1;
        exp_c   = (n != 0) ? exp[0] : 1'b0;
        @(negedge clk);
        start = 1'b1;
        operand1 = a;
        immediate_offset = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        operand1 = ~a;
        immediate_offset = n + 4'd1;
        lat = 1;
        nbusy = busy ? 1 : 0;
        while (!done && lat < 40) begin
            if (mid && lat == 5) begin
                start = 1'b1;
                operand1 = 16'hFFFF;
                immediate_offset = 4'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (busy) nbusy++;
        end
        start = 1'b0;
        check({tag, ".done_seen"}, done, 1);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".busy_cycles"}, nbusy, exp_lat);
        check({tag, ".dout"}, dout, exp);
        check({tag, ".carry"}, carry, exp_c);
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".idle_busy"}, busy, 0);
        check({tag, ".dout_held"}, dout, exp);
    endtask

    initial begin
        int pulses[3];
        int np;
        int cyc;
        logic [15:0] a;
        logic [3:0]  n;
        bit seen;

        // Reset for 3 cycles, then idle: outputs all zero every cycle.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) reset = 1'b0;
            check($sformatf("idle%0d.busy", i), busy, 0);
            check($sformatf("idle%0d.done", i), done, 0);
            check($sformatf("idle%0d.dout", i), dout, 16'h0000);
            check($sformatf("idle%0d.carry", i), carry, 0);
        end

        do_op("rol1",    16'h8001, 4'd1,  16'h0003, 1'b0);
        do_op("rol4",    16'h1234, 4'd4,  16'h2341, 1'b0);
        do_op("rol0",    16'h1234, 4'd0,  16'h1234, 1'b0);
        do_op("rol15",   16'h0001, 4'd15, 16'h8000, 1'b1);
        do_op("ones7",   16'hFFFF, 4'd7,  16'hFFFF, 1'b0);
        do_op("zeros9",  16'h0000, 4'd9,  16'h0000, 1'b0);
        do_op("rol8",    16'h00FF, 4'd8,  16'hFF00, 1'b0);

        // Reset mid-operation: result discarded, no done pulse.
        @(negedge clk);
        start = 1'b1;
        operand1 = 16'hA5C3;
        immediate_offset = 4'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = done;
        @(posedge clk);
        #1;
        seen = seen | done;
        reset = 1'b1;
        @(posedge clk);
        #1;
        seen = seen | done;
        reset = 1'b0;
        check("rst.no_done", seen, 0);
        check("rst.busy", busy, 0);
        check("rst.dout", dout, 16'h0000);
        check("rst.carry", carry, 0);
        do_op("rst.fresh", 16'hA5C3, 4'd7, 16'hE1D2, 1'b0);

        // Start held high: one op per N+2 cycles, first done N+1 edges after sampling.
        @(negedge clk);
        start = 1'b1;
        operand1 = 16'h00F0;
        immediate_offset = 4'd3;
        np = 0;
        cyc = 0;
        while (np < 3 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                pulses[np] = cyc;
                np++;
                check($sformatf("b2b%0d.dout", np), dout, 16'h0780);
            end
        end
        start = 1'b0;
        check("b2b.pulses", np, 3);
        check("b2b.first", pulses[0], 4);
        check("b2b.period1", pulses[1] - pulses[0], 5);
        check("b2b.period2", pulses[2] - pulses[1], 5);
        cyc = 0;
        while (busy && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("b2b.drain", busy, 0);

        // Sweep against the rotate-right identity.
        for (int k = 0; k < 1000; k++) begin
            a = 16'($urandom);
            n = 4'($urandom_range(0, 15));
            do_op($sformatf("rnd%0d", k), a, n, ror(a, (16 - int'(n)) % 16), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
